// File: rtl/f1_start_sequencer.sv
// Timing/control stage feeding the F1 start-light FSM: step enable, random
// lights-out hold, start reset pulse, reaction timing and jump-start detection.
module f1_start_sequencer #(
    parameter int unsigned TICK_N = 24,
    parameter int unsigned STEPS  = 8,
    parameter logic [6:0]  SEED   = 7'h01,
    parameter int unsigned RT_W   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trigger,
    input  logic            react,
    output logic            seq_rst,
    output logic            step,
    output logic            lights_out,
    output logic [RT_W-1:0] react_time,
    output logic            valid,
    output logic            false_start,
    output logic            busy
);

    localparam int TW = (TICK_N > 1) ? $clog2(TICK_N) : 1;
    localparam int SW = $clog2(STEPS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_N - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(STEPS - 1);

    typedef enum logic [2:0] {
        IDLE,
        COUNT_UP,
        HOLD,
        TIMING,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [6:0]      lfsr;
    logic [TW-1:0]   tick_cnt, tick_cnt_nx, tick_wrap;
    logic [SW-1:0]   step_cnt, step_cnt_nx;
    logic [6:0]      hold_cnt, hold_cnt_nx;
    logic [RT_W-1:0] rt_cnt, rt_cnt_nx;
    logic [RT_W-1:0] react_time_nx;
    logic            seq_rst_nx, step_nx, lights_out_nx;
    logic            valid_nx, false_start_nx;
    logic            tick, start, jump, rst_req;

    assign tick      = (tick_cnt == TICK_LAST);
    assign tick_wrap = tick ? '0 : tick_cnt + TW'(1);

    assign start = trigger && (state == IDLE || state == DONE);
    assign jump  = react && (state == COUNT_UP || state == HOLD);

    // A reset request right after a pulse is dropped: the FSM is already in S0.
    assign rst_req = (start || jump) && !seq_rst;

    assign busy = (state == COUNT_UP) || (state == HOLD) || (state == TIMING);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
        end
    end

    always_comb begin
        state_nx       = state;
        tick_cnt_nx    = tick_cnt;
        step_cnt_nx    = step_cnt;
        hold_cnt_nx    = hold_cnt;
        rt_cnt_nx      = rt_cnt;
        react_time_nx  = react_time;
        valid_nx       = valid;
        false_start_nx = false_start;
        seq_rst_nx     = rst_req;
        step_nx        = 1'b0;
        lights_out_nx  = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                if (trigger) begin
                    state_nx    = COUNT_UP;
                    tick_cnt_nx = '0;
                    step_cnt_nx = '0;
                    valid_nx    = 1'b0;
                end
            end
            COUNT_UP: begin
                if (react) begin
                    state_nx       = DONE;
                    valid_nx       = 1'b1;
                    false_start_nx = 1'b1;
                    react_time_nx  = '0;
                end else begin
                    tick_cnt_nx = tick_wrap;
                    if (tick) begin
                        step_nx     = 1'b1;
                        step_cnt_nx = step_cnt + SW'(1);
                        if (step_cnt == STEP_LAST) begin
                            state_nx    = HOLD;
                            hold_cnt_nx = lfsr;
                        end
                    end
                end
            end
            HOLD: begin
                if (react) begin
                    state_nx       = DONE;
                    valid_nx       = 1'b1;
                    false_start_nx = 1'b1;
                    react_time_nx  = '0;
                end else begin
                    tick_cnt_nx = tick_wrap;
                    if (tick) begin
                        if (hold_cnt == 7'd1) begin
                            step_nx       = 1'b1;
                            lights_out_nx = 1'b1;
                            rt_cnt_nx     = '0;
                            state_nx      = TIMING;
                        end else begin
                            hold_cnt_nx = hold_cnt - 7'd1;
                        end
                    end
                end
            end
            TIMING: begin
                rt_cnt_nx = (rt_cnt == '1) ? rt_cnt : rt_cnt + RT_W'(1);
                if (react) begin
                    state_nx       = DONE;
                    react_time_nx  = rt_cnt;
                    valid_nx       = 1'b1;
                    false_start_nx = 1'b0;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            step_cnt    <= '0;
            hold_cnt    <= '0;
            rt_cnt      <= '0;
            react_time  <= '0;
            valid       <= 1'b0;
            false_start <= 1'b0;
            seq_rst     <= 1'b0;
            step        <= 1'b0;
            lights_out  <= 1'b0;
        end else begin
            state       <= state_nx;
            tick_cnt    <= tick_cnt_nx;
            step_cnt    <= step_cnt_nx;
            hold_cnt    <= hold_cnt_nx;
            rt_cnt      <= rt_cnt_nx;
            react_time  <= react_time_nx;
            valid       <= valid_nx;
            false_start <= false_start_nx;
            seq_rst     <= seq_rst_nx;
            step        <= step_nx;
            lights_out  <= lights_out_nx;
        end
    end

    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        !(step && seq_rst));
    a_rst_width: assert property (@(posedge clk) disable iff (rst)
        seq_rst |=> !seq_rst);
    a_lo_step: assert property (@(posedge clk) disable iff (rst)
        lights_out |-> step);

endmodule

// File: tb/tb_f1_start_sequencer.sv
// Scoreboard bench for f1_start_sequencer: expected pulses queued at stimulus
// time, popped and compared as the sequencer emits them.
module tb_f1_start_sequencer;

    localparam int         T    = 4;
    localparam int         RW   = 8;
    localparam logic [6:0] SEED = 7'h01;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          trigger = 1'b0;
    logic          react = 1'b0;
    logic          seq_rst, step, lights_out, valid, false_start, busy;
    logic [RW-1:0] react_time;

    always #5 clk = ~clk;

    f1_start_sequencer #(
        .TICK_N(T),
        .STEPS(8),
        .SEED(SEED),
        .RT_W(RW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .trigger(trigger),
        .react(react),
        .seq_rst(seq_rst),
        .step(step),
        .lights_out(lights_out),
        .react_time(react_time),
        .valid(valid),
        .false_start(false_start),
        .busy(busy)
    );

    typedef struct {
        int         cyc;
        logic [2:0] p;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev;
    int  nvec = 0;
    int  nerr = 0;
    int  cyc;
    int  lst;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic push(input int c, input logic [2:0] p);
        ev_t e;
        e.cyc = c;
        e.p   = p;
        exp_q.push_back(e);
    endtask

    function automatic logic [6:0] lfsr_at(input int n);
        logic [6:0] q;
        q = SEED;
        for (int i = 0; i < n; i++) q = {q[5:0], q[6] ^ q[5]};
        return q;
    endfunction

    function automatic logic [7:0] bar(input int n);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < n; i++) b[i] = 1'b1;
        return b;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Monitor: every pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && (seq_rst || step || lights_out)) begin
            chk("overlap", 32'(seq_rst & step), 32'd0);
            if (exp_q.size() == 0) begin
                chk("spurious", 32'({seq_rst, step, lights_out}), 32'd0);
            end else begin
                ev = exp_q.pop_front();
                chk("ev_cyc", cyc, ev.cyc);
                chk("ev_pulse", 32'({seq_rst, step, lights_out}), 32'(ev.p));
            end
        end
        if (rst || seq_rst) lst = 0;
        else if (step) lst = (lst == 8) ? 0 : lst + 1;
    end

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic start_run(input int nsteps, input bit full,
                             output int c0, output int lo);
        int h;
        @(negedge clk);
        trigger = 1'b1;
        c0 = cyc + 1;
        lo = 0;
        push(c0, 3'b100);
        for (int k = 1; k <= nsteps; k++) push(c0 + k * T, 3'b010);
        if (full) begin
            h  = int'(lfsr_at(c0 + 8 * T - 1));
            lo = c0 + 8 * T + h * T;
            push(lo, 3'b011);
        end
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic press();
        react = 1'b1;
        @(negedge clk);
        react = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, lo;
        repeat (2) @(negedge clk);
        chk("rst_seq_rst", 32'(seq_rst), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_lo", 32'(lights_out), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_fs", 32'(false_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rt", 32'(react_time), 32'd0);
        rst = 1'b0;

        @(negedge clk);
        press();
        chk("idle_react_valid", 32'(valid), 32'd0);
        chk("idle_react_busy", 32'(busy), 32'd0);

        // Full start with a 37-cycle reaction.
        start_run(8, 1'b1, c0, lo);
        wait_to(c0 + 1);
        chk("run_busy", 32'(busy), 32'd1);
        wait_to(c0 + 8 * T + 1);
        chk("hold_bar", 32'(bar(lst)), 32'hFF);
        chk("hold_pending", exp_q.size(), 1);
        wait_to(lo + 1);
        chk("lo_bar", 32'(bar(lst)), 32'h00);
        chk("lo_pending", exp_q.size(), 0);
        wait_to(lo + 37);
        press();
        chk("rt_valid", 32'(valid), 32'd1);
        chk("rt_time", 32'(react_time), 32'd37);
        chk("rt_fs", 32'(false_start), 32'd0);
        chk("rt_busy", 32'(busy), 32'd0);
        press();
        chk("done_react_ignored", 32'(react_time), 32'd37);

        // Jump start during the 5th light tick.
        start_run(5, 1'b0, c0, lo);
        chk("restart_valid", 32'(valid), 32'd0);
        wait_to(c0 + 5 * T + 1);
        push(c0 + 5 * T + 2, 3'b100);
        press();
        chk("js_fs", 32'(false_start), 32'd1);
        chk("js_valid", 32'(valid), 32'd1);
        chk("js_rt", 32'(react_time), 32'd0);
        chk("js_busy", 32'(busy), 32'd0);
        repeat (10 * T) @(negedge clk);
        chk("js_bar", 32'(bar(lst)), 32'h00);
        chk("js_pending", exp_q.size(), 0);

        // No reaction: counter saturates at 255.
        start_run(8, 1'b1, c0, lo);
        wait_to(lo + 300);
        press();
        chk("sat_rt", 32'(react_time), 32'd255);
        chk("sat_valid", 32'(valid), 32'd1);
        chk("sat_fs", 32'(false_start), 32'd0);

        // Asynchronous reset in the middle of HOLD.
        start_run(8, 1'b0, c0, lo);
        wait_to(c0 + 8 * T + 2);
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_rt", 32'(react_time), 32'd0);
        chk("arst_pulses", 32'({seq_rst, step, lights_out}), 32'd0);
        chk("arst_pending", exp_q.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        start_run(8, 1'b1, c0, lo);
        wait_to(lo + 5);
        press();
        chk("after_rt", 32'(react_time), 32'd5);
        chk("after_valid", 32'(valid), 32'd1);
        repeat (4) @(negedge clk);
        chk("after_pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/f1_start_sequencer.md
Name: f1_start_sequencer

Overview:
- Timing and control stage directly upstream of the F1 start-light FSM.
- Generates the FSM's step enable, including the random "lights out" hold, and a start reset pulse.
- Measures driver reaction time after lights out and flags jump starts.
- Outputs drive the light FSM's en and rst inputs; the FSM's 8-bit light bar is not fed back.

Parameters:
- TICK_N, 24, clock cycles per light tick (>=2).
- STEPS, 8, light-on steps before hold (matches FSM S1..S8).
- SEED, 7'h01, LFSR reset value (must be non-zero).
- RT_W, 16, reaction counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- trigger  in  1  start request, level-sampled
- react  in  1  driver button, level-sampled, already synchronised
- seq_rst  out  1  one-cycle pulse, drives light FSM rst
- step  out  1  one-cycle pulse, drives light FSM en
- lights_out  out  1  one-cycle pulse coincident with final step
- react_time  out  RT_W  latched reaction count in clk cycles
- valid  out  1  react_time/false_start are valid
- false_start  out  1  react seen before lights out
- busy  out  1  high in COUNT_UP, HOLD, TIMING

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, rst).
- Reset values:
  - state = IDLE.
  - All pulse outputs 0; busy 0; valid 0; false_start 0; react_time 0.
  - Tick counter 0; step counter 0; LFSR = SEED.
- LFSR:
  - 7-bit, free-running every cycle, including IDLE.
  - Update: q <= {q[5:0], q[6]^q[5]}.
  - Never zero; period 127.
- Tick counter:
  - Cleared to 0 on entry to COUNT_UP.
  - Counts 0..TICK_N-1 and wraps while in COUNT_UP or HOLD.
  - tick = (count == TICK_N-1).
- States:
  - IDLE:
    - trigger=1 -> COUNT_UP.
    - seq_rst high for the first cycle in COUNT_UP (registered).
  - COUNT_UP:
    - step = tick; step counter increments on each step.
    - On the STEPS-th step -> HOLD.
    - Load hold_cnt with the current LFSR value (range 1..127) on that same edge.
    - First step occurs TICK_N cycles after COUNT_UP entry.
  - HOLD:
    - On each tick, hold_cnt decrements.
    - On the tick where hold_cnt==1: assert step and lights_out, clear reaction counter, -> TIMING.
    - Hold duration is exactly hold_cnt*TICK_N cycles.
  - TIMING:
    - Reaction counter increments every cycle, saturating at all-ones.
    - react=1 -> DONE; react_time <= counter value, valid <= 1, false_start <= 0.
    - react in the first TIMING cycle gives react_time=0.
  - DONE:
    - Outputs held.
    - trigger=1 -> COUNT_UP: clear valid, pulse seq_rst, restart counters.
- Jump start:
  - react=1 in COUNT_UP or HOLD -> DONE immediately, with no further step pulses.
  - Sets false_start=1, valid=1, react_time=0.
  - Also pulses seq_rst on that transition so the FSM returns to S0 (lights off).
- Ignored inputs:
  - trigger is ignored in COUNT_UP, HOLD and TIMING.
  - react is ignored in IDLE and DONE.
- Simultaneous events:
  - trigger and react in DONE: trigger wins.
  - react and the final HOLD tick in the same cycle: false start (lights_out suppressed).
- Pulse rules: step and seq_rst are never high in the same cycle; every pulse is exactly 1 cycle wide.
- Reset mid-operation: asynchronous return to IDLE; all outputs go to their reset values immediately, without waiting for a clock edge.
- busy = state in {COUNT_UP, HOLD, TIMING}.

Test Plan:
- Reset, then trigger for 1 cycle with TICK_N=4 -> seq_rst 1 cycle later; step pulses at 4, 8, ..., 32 cycles after COUNT_UP entry; exactly 8 step pulses before HOLD.
- Continue the same run -> HOLD lasts captured_lfsr*4 cycles (bench LFSR model, SEED=1); final step and lights_out coincide; FSM model reads 8'h00 afterwards.
- React asserted 37 cycles after lights_out -> valid=1, react_time=37, false_start=0, busy=0.
- React asserted during the 5th light tick -> false_start=1, valid=1, react_time=0, seq_rst pulse, no further step pulses.
- Never assert react with RT_W=8 -> react_time counter saturates at 255; a later react latches 255.
- rst asserted mid-HOLD, asynchronously between clock edges -> outputs zero before the next edge; a subsequent trigger restarts cleanly with 8 step pulses.
